dmem_responder: RTL

// Word-addressed data-memory responder: the memory side of the processor data port
// (memwrite / address / writedata out, readdata in). Adds a req/ready handshake with a

---
 rtl/dmem_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with req/ready handshake and wait states
// Captures a request in IDLE, waits LAT cycles, then pulses ready (with err on bad address).
module dmem_responder #(
    parameter int          DEPTH = 64,
    parameter int          LAT   = 2,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] LO        = {1'b0, BASE};
    localparam logic [32:0] HI        = LO + 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state, state_nx;
    logic [3:0]     cnt;
    logic           cap_we, cap_err;
    logic [AW-1:0]  cap_idx;
    logic [31:0]    cap_wdata;
    logic [31:0]    mem [DEPTH];

    logic           live_err;
    logic [AW-1:0]  live_idx;
    logic           src_we, src_err;
    logic [AW-1:0]  src_idx;

    // Compare in 33 bits so BASE+4*DEPTH at the top of the space cannot wrap.
    always_comb begin
        live_err = (addr[1:0] != 2'b00) || ({1'b0, addr} < LO) || ({1'b0, addr} >= HI);
        live_idx = AW'((addr - BASE) >> 2);
    end

    // With LAT=0 RESP is entered on the capture edge itself, so read from the live request.
    always_comb begin
        if (state == S_IDLE) begin
            src_we  = memwrite;
            src_err = live_err;
            src_idx = live_idx;
        end else begin
            src_we  = cap_we;
            src_err = cap_err;
            src_idx = cap_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = (LAT == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_RESP);
        err   = (state == S_RESP) && cap_err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'h0;
            readdata  <= 32'h0;
        end else begin
            if (state == S_IDLE && req) begin
                cap_we    <= memwrite;
                cap_err   <= live_err;
                cap_idx   <= live_idx;
                cap_wdata <= writedata;
                cnt       <= WAIT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state != S_RESP && state_nx == S_RESP && !src_we)
                readdata <= src_err ? 32'h0 : mem[src_idx];
        end
    end

    // Store commits on the edge ending RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (reset && state == S_RESP && cap_we && !cap_err)
            mem[cap_idx] <= cap_wdata;
    end

endmodule
